// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, select, exception and opcode encodings for the multi-cycle controller
package mips_ctrl_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXC    = 3'd5
    } state_t;

    typedef enum logic [4:0] {
        C_NOP, C_ADDU, C_SUBU, C_ADD, C_SUB, C_AND, C_ORI, C_ANDI, C_LUI,
        C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_MFC0, C_MTC0, C_ERET, C_ILL
    } iclass_t;

    localparam logic [2:0] PC_PLUS4 = 3'd0, PC_BRANCH = 3'd1, PC_JUMP = 3'd2,
                           PC_RS = 3'd3, PC_VEC = 3'd4, PC_EPC = 3'd5;
    localparam logic [1:0] RS_ALU = 2'd0, RS_MEM = 2'd1, RS_PC4 = 2'd2, RS_CP0 = 2'd3;
    localparam logic [1:0] AS_RT = 2'd0, AS_SIMM = 2'd1, AS_ZIMM = 2'd2, AS_LUI = 2'd3;
    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110;
    localparam logic [4:0] EXC_INT = 5'd0, EXC_RI = 5'd10, EXC_OV = 5'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_COP0 = 6'h10,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                           F_SUBU = 6'h23, F_AND = 6'h24;
    localparam logic [4:0] CP0_MF = 5'h00, CP0_MT = 5'h04;
    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    function automatic logic is_rtype(iclass_t c);
        return c inside {C_ADDU, C_SUBU, C_ADD, C_SUB, C_AND};
    endfunction
endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath bundle (decode inputs, strobes, selects)
interface mips_multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero, ovf, irq, exl;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, RegDst;
    logic [1:0]  ALUSrc;
    logic [2:0]  ALUControl;
    logic [1:0]  RegSrc;
    logic [2:0]  PCSrc;
    logic        CP0Write, EPCWrite, EXLClr;
    logic [4:0]  ExcCode;
    logic [2:0]  state;

    modport master (
        input  instr, zero, ovf, irq, exl,
        output PCWrite, IRWrite, MemWrite, RegWrite, RegDst, ALUSrc, ALUControl,
               RegSrc, PCSrc, CP0Write, EPCWrite, EXLClr, ExcCode, state
    );
    modport slave (
        output instr, zero, ovf, irq, exl,
        input  PCWrite, IRWrite, MemWrite, RegWrite, RegDst, ALUSrc, ALUControl,
               RegSrc, PCSrc, CP0Write, EPCWrite, EXLClr, ExcCode, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl_instr_class.sv
// mips_instr_class: maps the instruction word to an instruction class and a legal flag
module mips_instr_class import mips_ctrl_pkg::*; (
    input  logic [31:0] instr,
    output iclass_t     cls,
    output logic        legal
);
    // classify by opcode, then funct for R-type and rs for COP0; anything unmatched is illegal
    always_comb begin
        cls = C_ILL;
        if (instr == 32'h0)
            cls = C_NOP;
        else
            case (instr[31:26])
                OP_RTYPE:
                    case (instr[5:0])
                        F_ADDU:  cls = C_ADDU;
                        F_SUBU:  cls = C_SUBU;
                        F_ADD:   cls = C_ADD;
                        F_SUB:   cls = C_SUB;
                        F_AND:   cls = C_AND;
                        F_JR:    cls = C_JR;
                        default: cls = C_ILL;
                    endcase
                OP_J:    cls = C_J;
                OP_JAL:  cls = C_JAL;
                OP_BEQ:  cls = C_BEQ;
                OP_ANDI: cls = C_ANDI;
                OP_ORI:  cls = C_ORI;
                OP_LUI:  cls = C_LUI;
                OP_LW:   cls = C_LW;
                OP_SW:   cls = C_SW;
                OP_COP0: cls = instr[25:21] == CP0_MF ? C_MFC0 :
                               instr[25:21] == CP0_MT ? C_MTC0 :
                               instr == ERET_WORD     ? C_ERET : C_ILL;
                default: cls = C_ILL;
            endcase
    end

    assign legal = cls != C_ILL;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS sequencing FSM; define CTRL_INT_EN to enable interrupt entry
module mips_multicycle_ctrl import mips_ctrl_pkg::*; #(
    parameter int FETCH_WAIT = 1,
    parameter int DATA_WAIT  = 1
) (
    input logic clk,
    input logic reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam int MAXW = FETCH_WAIT > DATA_WAIT ? FETCH_WAIT : DATA_WAIT;
    localparam int CW = $clog2(MAXW + 1);

    state_t         state, nxt;
    logic [CW-1:0]  cnt;
    logic [4:0]     exc_q, exc_nxt;
    iclass_t        cls;
    logic           legal;
    logic           fetch_last, data_last;
    logic [1:0]     alu_src;
    logic [2:0]     alu_ctl;

    mips_instr_class u_class (
        .instr (bus.instr),
        .cls   (cls),
        .legal (legal)
    );

`ifndef CTRL_INT_EN
    logic unused_int;
    assign unused_int = bus.irq ^ bus.exl;
`endif

    assign fetch_last = cnt == CW'(FETCH_WAIT - 1);
    assign data_last  = cnt == CW'(DATA_WAIT - 1);
    assign alu_src = cls inside {C_ORI, C_ANDI} ? AS_ZIMM :
                     cls == C_LUI               ? AS_LUI  :
                     cls inside {C_LW, C_SW}    ? AS_SIMM : AS_RT;
    assign alu_ctl = cls inside {C_SUBU, C_SUB, C_BEQ} ? ALU_SUB :
                     cls inside {C_AND, C_ANDI}        ? ALU_AND :
                     cls inside {C_ORI, C_LUI}         ? ALU_OR  : ALU_ADD;
    assign bus.state = state;

    // state, wait counter (cleared on every transition) and pending exception cause
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
            exc_q <= EXC_INT;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? '0 : cnt + 1'b1;
            exc_q <= exc_nxt;
        end
    end

    // next state and Moore outputs; everything is held at zero while reset is asserted
    always_comb begin
        nxt            = state;
        exc_nxt        = exc_q;
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.RegDst     = 1'b0;
        bus.ALUSrc     = AS_RT;
        bus.ALUControl = ALU_AND;
        bus.RegSrc     = RS_ALU;
        bus.PCSrc      = PC_PLUS4;
        bus.CP0Write   = 1'b0;
        bus.EPCWrite   = 1'b0;
        bus.EXLClr     = 1'b0;
        bus.ExcCode    = EXC_INT;
        if (!reset) begin
            if (state inside {S_EXEC, S_MEM, S_WB}) begin
                bus.ALUSrc     = alu_src;
                bus.ALUControl = alu_ctl;
            end
            case (state)
                S_FETCH: begin
`ifdef CTRL_INT_EN
                    if (cnt == '0 && bus.irq && !bus.exl) begin
                        nxt     = S_EXC;
                        exc_nxt = EXC_INT;
                    end else
`endif
                    if (fetch_last) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        nxt         = S_DECODE;
                    end
                end
                S_DECODE: begin
                    nxt = S_EXEC;
                    if (!legal) begin
                        nxt     = S_EXC;
                        exc_nxt = EXC_RI;
                    end else
                        case (cls)
                            C_J, C_JR: begin
                                bus.PCWrite = 1'b1;
                                bus.PCSrc   = cls == C_J ? PC_JUMP : PC_RS;
                                nxt         = S_FETCH;
                            end
                            C_JAL: begin
                                bus.PCWrite  = 1'b1;
                                bus.PCSrc    = PC_JUMP;
                                bus.RegWrite = 1'b1;
                                bus.RegSrc   = RS_PC4;
                                nxt          = S_FETCH;
                            end
                            C_MTC0: begin
                                bus.CP0Write = 1'b1;
                                nxt          = S_FETCH;
                            end
                            C_ERET: begin
                                bus.PCWrite = 1'b1;
                                bus.PCSrc   = PC_EPC;
                                bus.EXLClr  = 1'b1;
                                nxt         = S_FETCH;
                            end
                            C_MFC0:  nxt = S_WB;
                            C_NOP:   nxt = S_FETCH;
                            default: nxt = S_EXEC;
                        endcase
                end
                S_EXEC: begin
                    if (cls == C_BEQ) begin
                        bus.PCWrite = bus.zero;
                        bus.PCSrc   = PC_BRANCH;
                        nxt         = S_FETCH;
                    end else if (cls inside {C_ADD, C_SUB} && bus.ovf) begin
                        nxt     = S_EXC;
                        exc_nxt = EXC_OV;
                    end else
                        nxt = cls inside {C_LW, C_SW} ? S_MEM : S_WB;
                end
                S_MEM: begin
                    bus.MemWrite = cls == C_SW && cnt == '0;
                    if (data_last)
                        nxt = cls == C_SW ? S_FETCH : S_WB;
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = is_rtype(cls);
                    bus.RegSrc   = cls == C_LW ? RS_MEM : cls == C_MFC0 ? RS_CP0 : RS_ALU;
                    nxt          = S_FETCH;
                end
                S_EXC: begin
                    bus.EPCWrite = 1'b1;
                    bus.PCWrite  = 1'b1;
                    bus.PCSrc    = PC_VEC;
                    bus.ExcCode  = exc_q;
                    nxt          = S_FETCH;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench, per-cycle expected outputs queued by stimulus and checked by a monitor
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam int FW = 2;
    localparam int DW = 3;

    localparam logic [6:0] NONE = 7'h00, PCW = 7'h40, IRW = 7'h20, MEMW = 7'h10, REGW = 7'h08,
                           CP0W = 7'h04, EPCW = 7'h02, EXLC = 7'h01;
    localparam logic [5:0] E_ST = 6'h20, E_RD = 6'h10, E_ALU = 6'h08, E_RS = 6'h04,
                           E_PS = 6'h02, E_EC = 6'h01;

    typedef struct packed {
        logic       pcw, irw, memw, regw, regdst;
        logic [1:0] alusrc;
        logic [2:0] aluc;
        logic [1:0] regsrc;
        logic [2:0] pcsrc;
        logic       cp0w, epcw, exlclr;
        logic [4:0] exc;
        logic [2:0] st;
    } vec_t;

    typedef struct {
        vec_t  exp;
        vec_t  mask;
        string tag;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;
    rec_t q[$];
    vec_t act;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.FETCH_WAIT(FW), .DATA_WAIT(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign act = {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.RegDst, bus.ALUSrc,
                  bus.ALUControl, bus.RegSrc, bus.PCSrc, bus.CP0Write, bus.EPCWrite, bus.EXLClr,
                  bus.ExcCode, bus.state};

    task automatic push(input string t, input logic [2:0] st, input logic [6:0] stb,
                        input logic [5:0] en = E_ST, input logic rd = 1'b0,
                        input logic [1:0] as = 2'd0, input logic [2:0] ac = 3'd0,
                        input logic [1:0] rs = 2'd0, input logic [2:0] ps = 3'd0,
                        input logic [4:0] ec = 5'd0);
        rec_t r;
        r.tag  = t;
        r.exp  = '0;
        r.mask = '0;
        {r.exp.pcw, r.exp.irw, r.exp.memw, r.exp.regw, r.exp.cp0w, r.exp.epcw, r.exp.exlclr} = stb;
        {r.mask.pcw, r.mask.irw, r.mask.memw, r.mask.regw, r.mask.cp0w, r.mask.epcw, r.mask.exlclr} = 7'h7F;
        r.exp.st      = st;
        r.mask.st     = {3{en[5]}};
        r.exp.regdst  = rd;
        r.mask.regdst = en[4];
        r.exp.alusrc  = as;
        r.exp.aluc    = ac;
        r.mask.alusrc = {2{en[3]}};
        r.mask.aluc   = {3{en[3]}};
        r.exp.regsrc  = rs;
        r.mask.regsrc = {2{en[2]}};
        r.exp.pcsrc   = ps;
        r.mask.pcsrc  = {3{en[1]}};
        r.exp.exc     = ec;
        r.mask.exc    = {5{en[0]}};
        q.push_back(r);
    endtask

    task automatic fetch(input string t);
        for (int i = 0; i < FW - 1; i++) push(t, S_FETCH, NONE);
        push(t, S_FETCH, PCW | IRW, E_ST | E_PS, 1'b0, 2'd0, 3'd0, 2'd0, PC_PLUS4);
    endtask

    task automatic go(input logic [31:0] i, input logic z = 1'b0, input logic o = 1'b0);
        int n;
        n = q.size();
        bus.instr = i;
        bus.zero  = z;
        bus.ovf   = o;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // pop one expected record per cycle and compare the masked outputs
    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t r;
            r = q.pop_front();
            checks++;
            if (((act ^ r.exp) & r.mask) != '0) begin
                errors++;
                $display("FAIL %s: got %h required %h (mask %h) at %0t", r.tag, act, r.exp, r.mask, $time);
            end
        end else if (done) begin
            checks++;
            if (bus.state != S_FETCH || bus.PCWrite || bus.RegWrite || bus.MemWrite) begin
                errors++;
                $display("FAIL idle: state %0d pcw %b regw %b memw %b required FETCH with no strobes",
                         bus.state, bus.PCWrite, bus.RegWrite, bus.MemWrite);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        reset     = 1'b1;
        bus.instr = 32'h0;
        bus.zero  = 1'b0;
        bus.ovf   = 1'b0;
        bus.irq   = 1'b0;
        bus.exl   = 1'b0;
        @(posedge clk);
        #1;
        push("rst", S_FETCH, NONE, E_ST | E_RD | E_ALU | E_RS | E_PS | E_EC);
        push("rst", S_FETCH, NONE, E_ST | E_RD | E_ALU | E_RS | E_PS | E_EC);
        go(32'h0);
        reset = 1'b0;

        fetch("addu");
        push("addu", S_DECODE, NONE);
        push("addu", S_EXEC, NONE, E_ST | E_ALU, 1'b0, AS_RT, ALU_ADD);
        push("addu", S_WB, REGW, E_ST | E_RD | E_ALU | E_RS, 1'b1, AS_RT, ALU_ADD, RS_ALU);
        go(32'h0022_1821);

        fetch("lw");
        push("lw", S_DECODE, NONE);
        push("lw", S_EXEC, NONE, E_ST | E_ALU, 1'b0, AS_SIMM, ALU_ADD);
        for (int i = 0; i < DW; i++) push("lw_mem", S_MEM, NONE);
        push("lw", S_WB, REGW, E_ST | E_RD | E_RS, 1'b0, 2'd0, 3'd0, RS_MEM);
        go(32'h8C22_0004);

        fetch("sw");
        push("sw", S_DECODE, NONE);
        push("sw", S_EXEC, NONE, E_ST | E_ALU, 1'b0, AS_SIMM, ALU_ADD);
        push("sw_mem0", S_MEM, MEMW);
        for (int i = 1; i < DW; i++) push("sw_mem", S_MEM, NONE);
        go(32'hAC22_0004);

        fetch("beq_nt");
        push("beq_nt", S_DECODE, NONE);
        push("beq_nt", S_EXEC, NONE, E_ST | E_ALU, 1'b0, AS_RT, ALU_SUB);
        go(32'h1022_0003, 1'b0);

        fetch("beq_t");
        push("beq_t", S_DECODE, NONE);
        push("beq_t", S_EXEC, PCW, E_ST | E_PS, 1'b0, 2'd0, 3'd0, 2'd0, PC_BRANCH);
        go(32'h1022_0003, 1'b1);

        fetch("add_ov");
        push("add_ov", S_DECODE, NONE);
        push("add_ov", S_EXEC, NONE);
        push("add_ov", S_EXC, PCW | EPCW, E_ST | E_PS | E_EC, 1'b0, 2'd0, 3'd0, 2'd0, PC_VEC, EXC_OV);
        go(32'h0022_1820, 1'b0, 1'b1);

        fetch("ri");
        push("ri", S_DECODE, NONE);
        push("ri", S_EXC, PCW | EPCW, E_ST | E_PS | E_EC, 1'b0, 2'd0, 3'd0, 2'd0, PC_VEC, EXC_RI);
        go(32'hFC00_0000);

        fetch("j");
        push("j", S_DECODE, PCW, E_ST | E_PS, 1'b0, 2'd0, 3'd0, 2'd0, PC_JUMP);
        go(32'h0800_0010);

        fetch("jal");
        push("jal", S_DECODE, PCW | REGW, E_ST | E_PS | E_RS, 1'b0, 2'd0, 3'd0, RS_PC4, PC_JUMP);
        go(32'h0C00_0010);

        fetch("jr");
        push("jr", S_DECODE, PCW, E_ST | E_PS, 1'b0, 2'd0, 3'd0, 2'd0, PC_RS);
        go(32'h03E0_0008);

        fetch("mtc0");
        push("mtc0", S_DECODE, CP0W);
        go(32'h4082_6000);

        fetch("mfc0");
        push("mfc0", S_DECODE, NONE);
        push("mfc0", S_WB, REGW, E_ST | E_RD | E_RS, 1'b0, 2'd0, 3'd0, RS_CP0);
        go(32'h4002_6000);

        fetch("eret");
        push("eret", S_DECODE, PCW | EXLC, E_ST | E_PS, 1'b0, 2'd0, 3'd0, 2'd0, PC_EPC);
        go(32'h4200_0018);

        fetch("nop");
        push("nop", S_DECODE, NONE);
        go(32'h0);

        fetch("andi");
        push("andi", S_DECODE, NONE);
        push("andi", S_EXEC, NONE, E_ST | E_ALU, 1'b0, AS_ZIMM, ALU_AND);
        push("andi", S_WB, REGW, E_ST | E_RD | E_ALU | E_RS, 1'b0, AS_ZIMM, ALU_AND, RS_ALU);
        go(32'h3022_0005);

        fetch("ori");
        push("ori", S_DECODE, NONE);
        push("ori", S_EXEC, NONE, E_ST | E_ALU, 1'b0, AS_ZIMM, ALU_OR);
        push("ori", S_WB, REGW, E_ST | E_RD | E_RS, 1'b0, 2'd0, 3'd0, RS_ALU);
        go(32'h3422_0005);

        fetch("sub");
        push("sub", S_DECODE, NONE);
        push("sub", S_EXEC, NONE, E_ST | E_ALU, 1'b0, AS_RT, ALU_SUB);
        push("sub", S_WB, REGW, E_ST | E_RD | E_RS, 1'b1, 2'd0, 3'd0, RS_ALU);
        go(32'h0022_1822, 1'b0, 1'b0);

        bus.irq = 1'b1;
        bus.exl = 1'b1;
        fetch("irq_exl");
        push("irq_exl", S_DECODE, PCW, E_ST | E_PS, 1'b0, 2'd0, 3'd0, 2'd0, PC_JUMP);
        go(32'h0800_0010);
        bus.exl = 1'b0;
`ifdef CTRL_INT_EN
        push("irq", S_FETCH, NONE);
        push("irq", S_EXC, PCW | EPCW, E_ST | E_PS | E_EC, 1'b0, 2'd0, 3'd0, 2'd0, PC_VEC, EXC_INT);
        go(32'h0800_0010);
`else
        fetch("irq_off");
        push("irq_off", S_DECODE, PCW, E_ST | E_PS, 1'b0, 2'd0, 3'd0, 2'd0, PC_JUMP);
        go(32'h0800_0010);
`endif
        bus.irq = 1'b0;

        fetch("sw_rst");
        push("sw_rst", S_DECODE, NONE);
        push("sw_rst", S_EXEC, NONE);
        go(32'hAC22_0004);
        reset = 1'b1;
        push("rst_mid", S_MEM, NONE, E_RD | E_ALU | E_RS | E_PS | E_EC);
        go(32'hAC22_0004);
        reset = 1'b0;
        fetch("restart");
        push("restart", S_DECODE, NONE);
        go(32'h0);

        done = 1'b1;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencing controller for the MIPS core: decodes the instruction in the instruction register and steps a Moore-style FSM through FETCH, DECODE, EXEC, MEM, WB and EXC. It generates per-cycle write strobes and mux selects for a shared-datapath CPU. It extends the single-cycle decoder's instruction set with wait-state-parametrised memory access, precise RI/overflow exceptions, EPC capture and optional interrupt entry.

## Interface
- FETCH_WAIT, 1: cycles an instruction fetch occupies (≥1).
- DATA_WAIT, 1: cycles a data access occupies (≥1).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  current instruction-register contents.
- zero  in  1  ALU equality flag (beq).
- ovf  in  1  ALU signed overflow (add/sub).
- irq  in  1  external interrupt request, level.
- exl  in  1  CP0 exception level; 1 blocks interrupts.
- PCWrite, IRWrite, MemWrite, RegWrite  out  1 each  write strobes.
- RegDst  out  1  1 = rd, 0 = rt.
- ALUSrc  out  2  0 = rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = imm<<16.
- ALUControl  out  3  000 and, 001 or, 010 add, 110 sub.
- RegSrc  out  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = CP0.
- PCSrc  out  3  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs, 4 = vector 0x0000_4180, 5 = EPC.
- CP0Write, EPCWrite, EXLClr  out  1 each  CP0 strobes.
- ExcCode  out  5  valid while EPCWrite = 1.
- state  out  3  current FSM state, for debug.

## Operation
- Supported instructions: addu, subu, add, sub, and, ori, andi, lui, lw, sw, beq, j, jal, jr, mfc0, mtc0, eret, nop (all-zero word).
- Any other encoding is illegal and raises RI.
- **FETCH:** held FETCH_WAIT cycles. On the last cycle: IRWrite = 1, PCWrite = 1, PCSrc = 0; next state DECODE.
- **DECODE** (1 cycle):
  - j/jr: PCWrite = 1, PCSrc = 2/3 → FETCH.
  - jal: additionally RegWrite = 1, RegSrc = 2, write to $31 → FETCH.
  - mtc0: CP0Write = 1 → FETCH.
  - eret: PCWrite = 1, PCSrc = 5, EXLClr = 1 → FETCH.
  - mfc0: → WB with RegSrc = 3, RegDst = 0.
  - nop: → FETCH.
  - illegal: → EXC with ExcCode 10.
  - all others: → EXC state... no: all others → EXEC.
- **EXEC** (1 cycle): ALUSrc/ALUControl per instruction.
  - beq: PCWrite = zero, PCSrc = 1 → FETCH.
  - add/sub with ovf = 1: → EXC with ExcCode 12.
  - lw/sw: → MEM.
  - otherwise: → WB.
- **MEM:** held DATA_WAIT cycles.
  - sw: MemWrite = 1 on the first MEM cycle only → FETCH.
  - lw: → WB.
- **WB** (1 cycle): RegWrite = 1. RegSrc = 1 for lw, 3 for mfc0, 0 otherwise. RegDst = 1 for R-type → FETCH.
- **EXC** (1 cycle): EPCWrite = 1, PCWrite = 1, PCSrc = 4, ExcCode driven → FETCH.
- EPC value:
  - RI and overflow: EPCWrite captures PC-4 (the faulting instruction).
  - interrupt: EPCWrite captures PC (the next instruction).
- Exceptions suppress every architectural write of the faulting instruction: RegWrite, MemWrite and CP0Write are never asserted for it.

## Timing
- Reset: state = FETCH, wait counter = 0, every strobe = 0, every select = 0.
- Reset asserted mid-instruction: no strobe fires in the reset cycle; FETCH restarts on the cycle after release.
- Outputs are combinational from state, counter and instr. The only Mealy input terms are PCWrite (from zero) and the EXEC→EXC transition (from ovf).
- Instruction latency, counted from the first FETCH cycle:
  - j/jal/jr/eret/mtc0/nop: FETCH_WAIT+1.
  - beq: FETCH_WAIT+2.
  - mfc0: FETCH_WAIT+2.
  - ALU: FETCH_WAIT+3.
  - sw: FETCH_WAIT+2+DATA_WAIT.
  - lw: FETCH_WAIT+3+DATA_WAIT.
- Wait counter: width $clog2(max(FETCH_WAIT, DATA_WAIT)+1). It clears on every state change and never wraps.

## Configuration
- CTRL_INT_EN defined:
  - irq is sampled on the first FETCH cycle.
  - If irq = 1 and exl = 0: → EXC with ExcCode 0; IRWrite and PCWrite stay 0 in that cycle.
  - Interrupts are taken only at instruction boundaries.
- CTRL_INT_EN undefined: irq is ignored; the port remains present.

## Structure
- Shared package mips_ctrl_pkg holds:
  - state encoding;
  - PCSrc, RegSrc and ALUControl codes;
  - ExcCode constants (INT = 0, RI = 10, OV = 12);
  - opcode/funct constants.
- One combinational sub-module, mips_instr_class, maps instr to an instruction class and a legal flag. The FSM lives in the top module.

## Test plan
- Hold reset 3 cycles, release, FETCH_WAIT = 2 → all strobes 0 during reset; IRWrite/PCWrite = 1 in cycle 2 after release.
- addu 0x00221821 → FETCH, FETCH, DECODE, EXEC, WB. RegWrite = 1 only in WB, with RegDst = 1 and ALUControl = 010.
- DATA_WAIT = 3:
  - lw 0x8C220004 → MEM lasts 3 cycles, then WB with RegSrc = 1.
  - sw 0xAC220004 → MemWrite high for exactly 1 cycle.
- beq 0x10220003:
  - zero = 0 → PCWrite never asserted after fetch.
  - zero = 1 → PCWrite = 1 with PCSrc = 1 in EXEC.
- Exceptions:
  - add 0x00221820 with ovf = 1 → EXC, ExcCode = 12, PCSrc = 4, no RegWrite.
  - Word 0xFC000000 → EXC from DECODE with ExcCode = 10.
- irq = 1, exl = 0 at an instruction boundary:
  - with CTRL_INT_EN → EXC with ExcCode 0 and no IRWrite;
  - without it → normal fetch.
